// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the branch predictor: prediction mode
//                encodings, direction-counter init values and PC index/tag
//                extraction helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_pkg;

    // Prediction mode encodings
    localparam int BP_STATIC_NT = 0;  // table trains, prediction forced not-taken
    localparam int BP_BIMODAL   = 1;  // prediction from counter MSB

    // Weakly-taken counter value: 2^(cnt_w-1)
    function automatic int unsigned bp_weak_taken(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    // Weakly-not-taken counter value: 2^(cnt_w-1)-1 (0 for a 1-bit counter)
    function automatic int unsigned bp_weak_not_taken(input int cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

    // Table index: pc[idx_w+1:2], zero-extended
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Partial tag: pc[idx_w+1+tag_w:idx_w+2], zero-extended
    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w,
                                           input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_sat_counter
//  Description : Combinational next-value logic for a WIDTH-bit saturating
//                up/down counter with load. Load has priority; simultaneous
//                inc and dec cancel.
//  Ports       : cur      - current counter value
//                inc/dec  - step up / down, saturating at all-ones / zero
//                load     - replace with load_val
//                nxt      - next counter value
//  Revision    : 1.0  initial release
// ============================================================================
module bp_sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (inc && !dec && (cur != {WIDTH{1'b1}})) begin
            nxt = cur + WIDTH'(1);
        end else if (dec && !inc && (cur != {WIDTH{1'b0}})) begin
            nxt = cur - WIDTH'(1);
        end
    end

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch target buffer with per-entry saturating
//                direction counters. Combinational lookup for IF, one resolved
//                update per cycle from EX, saturating branch/mispredict stats.
//  Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//                pc_i                    - fetch PC for lookup
//                hit_o, pred_taken_o,
//                next_pc_o               - lookup result
//                upd_valid_i, upd_pc_i,
//                upd_taken_i, upd_target_i,
//                upd_pred_taken_i        - resolved-branch update
//                branch_cnt_o,
//                mispred_cnt_o           - saturating statistics
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int MODE    = BP_BIMODAL,
    parameter int STAT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [31:0]       next_pc_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_pred_taken_i,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);

    localparam int         IDX_W       = $clog2(ENTRIES);
    localparam bit         C_BIMODAL   = (MODE == BP_BIMODAL);
    localparam [CNT_W-1:0] C_WEAK_T    = CNT_W'(bp_weak_taken(CNT_W));
    localparam [CNT_W-1:0] C_WEAK_NT   = CNT_W'(bp_weak_not_taken(CNT_W));

    // Flip-flop table: read is asynchronous, so no RAM inference
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];
    logic [CNT_W-1:0]  r_cnt    [ENTRIES];

    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispred_cnt;

    // ---------------- lookup (reads pre-update state, no bypass) ----------
    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;

    assign w_lk_idx     = IDX_W'(bp_index(pc_i, IDX_W));
    assign w_lk_tag     = TAG_W'(bp_tag(pc_i, IDX_W, TAG_W));
    assign hit_o        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken_o = hit_o && C_BIMODAL && r_cnt[w_lk_idx][CNT_W-1];
    assign next_pc_o    = pred_taken_o ? r_target[w_lk_idx] : (pc_i + 32'd4);

    // ---------------- update --------------------------------------------
    logic [IDX_W-1:0]  w_up_idx;
    logic [TAG_W-1:0]  w_up_tag;
    logic              w_up_hit;
    logic              w_wr_en;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_up_idx = IDX_W'(bp_index(upd_pc_i, IDX_W));
    assign w_up_tag = TAG_W'(bp_tag(upd_pc_i, IDX_W, TAG_W));
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    // A not-taken miss leaves the table untouched
    assign w_wr_en  = upd_valid_i && (w_up_hit || upd_taken_i);

    // Hit trains the counter; taken miss allocates at weakly-taken
    bp_sat_counter #(.WIDTH(CNT_W)) u_dir_cnt (
        .cur      (r_cnt[w_up_idx]),
        .inc      (w_up_hit && upd_taken_i),
        .dec      (w_up_hit && !upd_taken_i),
        .load     (!w_up_hit && upd_taken_i),
        .load_val (C_WEAK_T),
        .nxt      (w_cnt_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= C_WEAK_NT;
            end
        end else if (w_wr_en) begin
            r_valid[w_up_idx] <= 1'b1;
            r_tag[w_up_idx]   <= w_up_tag;
            r_cnt[w_up_idx]   <= w_cnt_nxt;
            if (upd_taken_i) begin
                r_target[w_up_idx] <= upd_target_i;
            end
        end
    end

    // ---------------- statistics ----------------------------------------
    logic [STAT_W-1:0] w_branch_nxt;
    logic [STAT_W-1:0] w_mispred_nxt;

    bp_sat_counter #(.WIDTH(STAT_W)) u_branch_cnt (
        .cur      (r_branch_cnt),
        .inc      (upd_valid_i),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ({STAT_W{1'b0}}),
        .nxt      (w_branch_nxt)
    );

    bp_sat_counter #(.WIDTH(STAT_W)) u_mispred_cnt (
        .cur      (r_mispred_cnt),
        .inc      (upd_valid_i && (upd_taken_i != upd_pred_taken_i)),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ({STAT_W{1'b0}}),
        .nxt      (w_mispred_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_branch_cnt  <= w_branch_nxt;
            r_mispred_cnt <= w_mispred_nxt;
        end
    end

    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Scoreboard bench for branch_predictor. Three instances share
//                one stimulus stream: default (bimodal, 16-bit stats), static
//                not-taken, and 2-bit statistics. A behavioural model predicts
//                every lookup; a monitor compares on the opposite clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;

    logic        hit_a, pred_a, hit_b, pred_b, hit_c, pred_c;
    logic [31:0] npc_a, npc_b, npc_c;
    logic [15:0] bcnt_a, mcnt_a, bcnt_b, mcnt_b;
    logic [1:0]  bcnt_c, mcnt_c;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .TAG_W(8), .MODE(1), .STAT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .hit_o(hit_a), .pred_taken_o(pred_a),
        .next_pc_o(npc_a), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred),
        .branch_cnt_o(bcnt_a), .mispred_cnt_o(mcnt_a));

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .TAG_W(8), .MODE(0), .STAT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .hit_o(hit_b), .pred_taken_o(pred_b),
        .next_pc_o(npc_b), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred),
        .branch_cnt_o(bcnt_b), .mispred_cnt_o(mcnt_b));

    branch_predictor #(.ENTRIES(16), .CNT_W(2), .TAG_W(8), .MODE(1), .STAT_W(2)) dut_c (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .hit_o(hit_c), .pred_taken_o(pred_c),
        .next_pc_o(npc_c), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred),
        .branch_cnt_o(bcnt_c), .mispred_cnt_o(mcnt_c));

    // ---------------- reference model (behavioural) ---------------------
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_branches;
    int unsigned m_mispreds;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        pred;     // bimodal prediction
        logic [31:0] npc;      // bimodal next pc
        int unsigned br;       // raw statistics, saturated at compare time
        int unsigned mp;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_branches = 0;
        m_mispreds = 0;
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a / 64) % 256;
    endfunction

    // Drive one cycle: inputs applied 1ns after the rising edge, expectation
    // derived from the model before this cycle's update is applied.
    task automatic step(input logic [31:0] l_pc, input bit uv, input logic [31:0] u_pc,
                        input bit ut, input logic [31:0] u_tgt, input bit up,
                        input bit r, input bit check);
        exp_t e;
        int unsigned li, ui;
        bit uhit;
        @(posedge clk);
        #1;
        rst = r; pc = l_pc; upd_valid = uv; upd_pc = u_pc;
        upd_taken = ut; upd_target = u_tgt; upd_pred = up;
        li = idx_of(l_pc);
        e.pc   = l_pc;
        e.hit  = m_valid[li] && (m_tag[li] == tag_of(l_pc));
        e.pred = e.hit && (m_ctr[li] >= 2);
        e.npc  = e.pred ? m_tgt[li] : l_pc + 32'd4;
        e.br   = m_branches;
        e.mp   = m_mispreds;
        if (check) exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else if (uv) begin
            ui = idx_of(u_pc);
            uhit = m_valid[ui] && (m_tag[ui] == tag_of(u_pc));
            m_branches++;
            if (ut != up) m_mispreds++;
            if (uhit) begin
                if (ut) begin
                    m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
                    m_tgt[ui] = u_tgt;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
                end
            end else if (ut) begin
                m_valid[ui] = 1'b1; m_tag[ui] = tag_of(u_pc);
                m_tgt[ui] = u_tgt; m_ctr[ui] = 2;
            end
        end
    endtask

    task automatic look(input logic [31:0] l_pc);
        step(l_pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic upd(input logic [31:0] l_pc, input logic [31:0] u_pc, input bit ut,
                       input logic [31:0] u_tgt, input bit up);
        step(l_pc, 1'b1, u_pc, ut, u_tgt, up, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- monitor -------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hit_a",   32'(hit_a),  32'(e.hit));
            chk("pred_a",  32'(pred_a), 32'(e.pred));
            chk("npc_a",   npc_a,       e.npc);
            chk("bcnt_a",  32'(bcnt_a), sat(e.br, 65535));
            chk("mcnt_a",  32'(mcnt_a), sat(e.mp, 65535));
            chk("hit_b",   32'(hit_b),  32'(e.hit));
            chk("pred_b",  32'(pred_b), 32'd0);
            chk("npc_b",   npc_b,       e.pc + 32'd4);
            chk("hit_c",   32'(hit_c),  32'(e.hit));
            chk("pred_c",  32'(pred_c), 32'(e.pred));
            chk("bcnt_c",  32'(bcnt_c), sat(e.br, 3));
            chk("mcnt_c",  32'(mcnt_c), sat(e.mp, 3));
        end
    end

    // ---------------- stimulus ------------------------------------------
    initial begin
        logic [31:0] rpc, rupc;
        rst = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred = 1'b0;
        model_reset();
        repeat (2) step(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Reset state
        look(32'h40);
        // Same-cycle lookup/update on empty table: lookup misses this cycle
        upd(32'h40, 32'h40, 1'b1, 32'h100, 1'b0);
        look(32'h40);                              // hit, taken, 0x100
        // Three not-taken updates then one taken
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b1);
        look(32'h40);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 32'h40, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        upd(32'h40, 32'h40, 1'b1, 32'h104, 1'b0);
        look(32'h40);                              // counter 01: not-taken
        // Alias: 0x80 shares index 0 with 0x40
        look(32'h80);
        upd(32'h80, 32'h80, 1'b1, 32'h200, 1'b1);
        look(32'h80);
        look(32'h40);
        // Low PC bits ignored
        look(32'h83);
        // Reset alongside an update discards it
        step(32'h80, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b1, 1'b1);
        look(32'h300);
        look(32'h80);
        // Five mispredicts: 2-bit stats saturate at 3
        for (int i = 0; i < 5; i++) upd(32'h10, 32'h10, 1'b1, 32'h400, 1'b0);
        look(32'h10);
        // 32-bit wrap of pc+4
        look(32'hFFFF_FFFC);

        // Randomized traffic over a small PC window to force hits and aliases
        for (int n = 0; n < 600; n++) begin
            rpc  = {$urandom_range(0, 63), 2'(($urandom_range(0, 3)))} ;
            rupc = {$urandom_range(0, 63), 2'(($urandom_range(0, 3)))} ;
            if ($urandom_range(0, 9) == 0) rpc = $urandom;
            step(rpc, ($urandom_range(0, 3) != 0), rupc, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 99) == 0), 1'b1);
        end

        // Drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 20;
            @(posedge clk);
            #1;
            upd_valid = 1'b0; rst = 1'b0;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor for the next-generation pipelined CPU, replacing the fixed single-cycle branch-type decision with fetch-stage prediction. It holds a direct-mapped table of ENTRIES branch-target entries, each with a partial tag, a target address and a saturating direction counter. The IF stage looks it up combinationally every cycle to form the next PC. The EX stage writes back resolved outcomes one update per cycle. It also keeps saturating branch and mispredict statistics.

## Interface
- ENTRIES, 16: table depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- CNT_W, 2: direction counter width, ≥1
- TAG_W, 8: partial tag width; IDX_W+2+TAG_W ≤ 32
- MODE, 1: 0 = static not-taken (table still trains, prediction forced 0); 1 = counter-based
- STAT_W, 16: statistics counter width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- pc_i  in  32  fetch PC for lookup
- hit_o  out  1  valid entry with matching tag at pc_i
- pred_taken_o  out  1  predicted taken
- next_pc_o  out  32  predicted next fetch PC
- upd_valid_i  in  1  resolved-branch update strobe
- upd_pc_i  in  32  PC of resolved branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  32  actual taken target
- upd_pred_taken_i  in  1  prediction that was used for this branch in IF
- branch_cnt_o  out  STAT_W  updates seen, saturating
- mispred_cnt_o  out  STAT_W  updates where upd_taken_i ≠ upd_pred_taken_i, saturating

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+1+TAG_W:IDX_W+2]. PC bits [1:0] are ignored.
- Lookup is purely combinational from pc_i and the current table:
  - hit_o = valid[idx] & (tag[idx] == pc tag)
  - pred_taken_o = hit_o & (MODE==1) & counter MSB
  - next_pc_o = pred_taken_o ? target[idx] : pc_i+4, with 32-bit wrap
- Update when upd_valid_i=1 and rst_i=0, keyed on upd_pc_i:
  - On a hit:
    - taken: counter incremented, saturating at 2^CNT_W−1; target overwritten with upd_target_i.
    - not taken: counter decremented, saturating at 0; target kept.
  - On a miss:
    - taken: allocate. Valid=1, tag written, target=upd_target_i, counter=2^(CNT_W−1) (weakly taken). This evicts any aliasing entry.
    - not taken: no table change.
- Statistics:
  - branch_cnt_o increments on every accepted update.
  - mispred_cnt_o increments when upd_taken_i ≠ upd_pred_taken_i.
  - Both hold at all-ones.

## Timing
- Lookup has zero latency (same-cycle). An update becomes visible to lookups from the cycle after its strobe.
- Lookup and update in the same cycle at the same index: the lookup returns the pre-update entry. There is no bypass.
- Only one update port exists, so updates have no ordering conflicts. Consecutive-cycle updates to one entry each apply in order.
- Reset (synchronous, takes priority over an update in the same cycle):
  - all valid=0
  - counters=2^(CNT_W−1)−1 (weakly not-taken)
  - targets=0, tags=0
  - statistics=0
- Reset outputs follow from reset state: hit_o=0, pred_taken_o=0, next_pc_o=pc_i+4, branch_cnt_o=0, mispred_cnt_o=0.
- Reset asserted mid-stream discards the update presented in that cycle.
- CNT_W=1: the counter is a last-outcome bit. Allocation sets it to 1; reset sets it to 0.

## Structure
- Package bp_pkg holds:
  - MODE encodings (BP_STATIC_NT=0, BP_BIMODAL=1)
  - the counter init functions, weak-taken/weak-not-taken as functions of CNT_W
  - the index/tag extraction functions
- Sub-module bp_sat_counter: CNT_W-wide saturating up/down with load. Used for the per-entry next-value logic and, at width STAT_W, for the two statistics counters.
- Table storage is flip-flop arrays, not inferred RAM, because read is asynchronous.

## Test plan
All cases use ENTRIES=16, CNT_W=2, TAG_W=8, MODE=1 unless stated.
- Reset, then pc_i=0x40 → hit_o=0, pred_taken_o=0, next_pc_o=0x44, both stats 0.
- Update 0x40 taken, target 0x100, pred 0 → next cycle lookup 0x40: hit_o=1, pred_taken_o=1, next_pc_o=0x100; branch_cnt=1, mispred_cnt=1.
- Three not-taken updates to 0x40 → counter 10→01→00→00; pred_taken_o=0 after the first. A taken update then returns the counter to 01, still predicted not-taken.
- Alias test:
  - Setup: 0x40 allocated, then lookup 0x80 (same index 0, tag 2 vs 1).
  - Expected before update: hit_o=0.
  - Action: taken update at 0x80, target 0x200.
  - Expected after: 0x80 hits with next_pc_o=0x200; 0x40 now misses.
- Same cycle: lookup 0x40 and taken update 0x40 on an empty table → that cycle hit_o=0; next cycle hit_o=1. Also assert rst_i alongside an update strobe → the table stays empty.
- Two configurations:
  - MODE=0: after a taken update, hit_o=1 but pred_taken_o=0 and next_pc_o=pc+4.
  - STAT_W=2: five mispredicting updates → mispred_cnt_o holds at 3.
